mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised successor to the fixed-terminal counter used by the keyboard/LED display logic. Counts qualified increment requests with optional prescaling, up or down, against a runtime limit, in wrap, saturate or one-shot mode. Provides a combinational terminal flag, a registered one-cycle wrap pulse and a one-shot done flag. Used for scan-column sequencing, debounce timing and LED blink dividers.

## Interface
- WIDTH, 8, counter width in bits.
- PRESC, 1, number of qualified `inc` cycles per counter step; valid range is ≥1.
- PW, $clog2(PRESC)+1, prescaler width (derived; do not override).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load of `load_val`; in one-shot mode it also starts a run.
- load_val  in  WIDTH  load value.
- inc  in  1  count request, sampled every cycle.
- dir  in  1  1 = up, 0 = down.
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 behaves as wrap.
- limit  in  WIDTH  runtime upper bound, sampled every cycle.
- cnt  out  WIDTH  registered count.
- at_term  out  1  combinational terminal flag: up → `cnt >= limit`; down → `cnt == 0`.
- wrap  out  1  registered one-cycle pulse on wrap or on one-shot completion.
- done  out  1  registered one-shot completion level.

## Operation
- **Priority:** reset > clr > load > step.
- **Reset** (asynchronous) and **clr** both set: `cnt=0`, prescaler=0, `wrap=0`, `done=0`, FSM=IDLE.
- **load:** `cnt<=load_val`, prescaler<=0, `done<=0`, `wrap<=0`.
  - In mode 10, FSM goes to RUN.
  - If `load_val` is already terminal, the next step completes the run.
- **Prescaler:** counts cycles with `inc`=1. `step = inc && (presc == PRESC-1)`; the prescaler returns to 0 on step.
  - With PRESC=1, `step = inc`.
  - The prescaler holds while `inc`=0.
- **Mode 00/11 (wrap), on step:**
  - Up, `at_term`: `cnt<=0`, `wrap<=1`. Otherwise `cnt<=cnt+1`.
  - Down, `cnt==0`: `cnt<=limit`, `wrap<=1`. Otherwise `cnt<=cnt-1`.
- **Mode 01 (saturate), on step:**
  - If `at_term`: `cnt` holds, `wrap` stays 0.
  - Otherwise `cnt` increments or decrements by 1.
  - Up with `cnt>limit` (limit lowered at runtime): `cnt<=limit`.
- **Mode 10 (one-shot) FSM:**
  - **IDLE:** steps ignored, `cnt` holds. `load` → RUN.
  - **RUN:** a step moves `cnt` by ±1. When the new value is terminal (up: `>= limit`; down: `==0`): `wrap<=1`, `done<=1`, → DONE. A step taken while already terminal (e.g. after loading a terminal value) also completes the run and leaves `cnt` unchanged.
  - **DONE:** steps ignored, `cnt` and `done` hold. `load` → RUN. `clr` → IDLE.
- **Mode change mid-count:** takes effect on the next step. `cnt` is unchanged. The FSM stays in its state but is only acted on in mode 10.
- **Arithmetic:** modulo 2^WIDTH internally, but `at_term` prevents crossing the limit in up mode.
  - With `limit = 2^WIDTH-1`, up-wrap runs the full range.
- **limit=0, up, wrap:** `cnt` stays 0 and every step pulses `wrap`.
- `wrap` is 0 in any cycle not immediately following a wrapping or completing step.

## Timing
- `cnt` updates on the clk edge where step, load or clr is sampled. Latency is 1 cycle.
- `wrap` asserts in the same cycle the new `cnt` value appears, for exactly 1 cycle, even if steps occur back-to-back.
- `at_term` is combinational on `cnt`, `limit` and `dir`, with no register delay.
- `done` rises together with `wrap` and is level until load, clr or reset.
- Reset values: `cnt=0`, `wrap=0`, `done=0`. `at_term` follows (1 for up with limit=0; 1 for down).
- Reset asserted mid-run clears immediately, without waiting for a clock edge. The first step after deassertion requires a full PRESC qualified cycles.
- `load` and `inc` in the same cycle: load wins, the step is discarded and the prescaler is cleared.

## Test plan
- **Wrap up count:** WIDTH=4, PRESC=1, limit=9, up, mode 00, `inc` held high → `cnt` 0..9,0. `wrap` is high only in the cycle `cnt` returns to 0. `at_term` is high while `cnt`=9.
- **Prescaler:** PRESC=3, `inc` high 9 cycles → `cnt`=3. `inc` gapped (1,0,1,0,1) → 1 step, with the prescaler holding across the gaps.
- **Down wrap and saturate:**
  - Down, limit=5, mode 00, from 0 → 5,4,…,0,5, with `wrap` on each 0→5.
  - Mode 01, up, limit=5 → holds at 5, no `wrap`.
  - Limit lowered from 5 to 2 while `cnt`=4 → next step gives `cnt`=2.
- **One-shot:** mode 10, limit=4, load `load_val`=1 → 2,3,4, then `done`=1 and `wrap` pulses once. Further `inc` leaves `cnt`=4. Load 0 → RUN, `done`=0.
- **Priority and corners:**
  - `clr`, `load` and `inc` in the same cycle → `cnt`=0.
  - `load` with `inc` → `load_val`, no step.
  - limit=0, up wrap → `wrap` on every step.
  - Async reset mid-count → `cnt`=0 before the next edge.

Source files
------------

// File: rtl/mod_counter.sv
// Prescaled up/down counter with runtime limit and wrap, saturate or one-shot modes.
// Drives scan-column sequencing, debounce timing and LED blink dividers.
module mod_counter #(
   parameter int WIDTH = 8,
   parameter int PRESC = 1,
   parameter int PW    = $clog2(PRESC) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] cnt,
   output logic             at_term,
   output logic             wrap,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_cnt, w_cnt_nxt, w_cnt_step;
   logic [PW-1:0]    r_presc, w_presc_nxt;
   logic             r_wrap, w_wrap_nxt;
   logic             r_done, w_done_nxt;
   logic             w_step, w_at_term, w_new_term;

   assign w_at_term  = dir ? (r_cnt >= limit) : (r_cnt == '0);
   assign w_step     = inc && (r_presc == PW'(PRESC - 1));
   assign w_cnt_step = dir ? r_cnt + 1'b1 : r_cnt - 1'b1;
   assign w_new_term = dir ? (w_cnt_step >= limit) : (w_cnt_step == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_presc <= '0;
         r_wrap  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_presc <= w_presc_nxt;
         r_wrap  <= w_wrap_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_presc_nxt = r_presc;
      w_wrap_nxt  = 1'b0;
      w_done_nxt  = r_done;
      if (clr) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_presc_nxt = '0;
         w_done_nxt  = 1'b0;
      end else if (load) begin
         w_cnt_nxt   = load_val;
         w_presc_nxt = '0;
         w_done_nxt  = 1'b0;
         if (mode == 2'b10) w_state_nxt = S_RUN;
      end else begin
         if (inc) w_presc_nxt = w_step ? '0 : r_presc + 1'b1;
         if (w_step) begin
            case (mode)
               2'b01: begin
                  // A limit lowered below cnt snaps cnt back onto it.
                  if (dir && (r_cnt > limit)) w_cnt_nxt = limit;
                  else if (!w_at_term)        w_cnt_nxt = w_cnt_step;
               end
               2'b10: begin
                  if (r_state == S_RUN) begin
                     if (!w_at_term) w_cnt_nxt = w_cnt_step;
                     if (w_at_term || w_new_term) begin
                        w_wrap_nxt  = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                     end
                  end
               end
               default: begin
                  if (w_at_term) begin
                     w_cnt_nxt  = dir ? '0 : limit;
                     w_wrap_nxt = 1'b1;
                  end else begin
                     w_cnt_nxt  = w_cnt_step;
                  end
               end
            endcase
         end
      end
   end

   assign cnt     = r_cnt;
   assign at_term = w_at_term;
   assign wrap    = r_wrap;
   assign done    = r_done;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: two instances (PRESC=1 and PRESC=3) share stimulus
// and are checked every cycle against an arithmetic model, plus literal spot checks.
module tb_mod_counter;

   localparam int W   = 4;
   localparam int MOD = 16;
   localparam int PR [2] = '{1, 3};

   logic         clk, reset, clr, load, inc, dir;
   logic [W-1:0] load_val, limit;
   logic [1:0]   mode;
   logic [W-1:0] a_cnt, b_cnt;
   logic         a_at, b_at, a_wrap, b_wrap, a_done, b_done;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   // model state: run phase 0 = idle, 1 = running, 2 = finished
   int m_cnt [2] = '{0, 0};
   int m_pre [2] = '{0, 0};
   int m_wrp [2] = '{0, 0};
   int m_dn  [2] = '{0, 0};
   int m_ph  [2] = '{0, 0};

   mod_counter #(.WIDTH(W), .PRESC(1)) u_a (
      .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
      .inc(inc), .dir(dir), .mode(mode), .limit(limit),
      .cnt(a_cnt), .at_term(a_at), .wrap(a_wrap), .done(a_done));

   mod_counter #(.WIDTH(W), .PRESC(3)) u_b (
      .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
      .inc(inc), .dir(dir), .mode(mode), .limit(limit),
      .cnt(b_cnt), .at_term(b_at), .wrap(b_wrap), .done(b_done));

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int term_of(input int c);
      return dir ? int'(c >= int'(limit)) : int'(c == 0);
   endfunction

   always @(posedge clk or posedge reset) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_wrp[k] = 0; m_dn[k] = 0; m_ph[k] = 0;
         end else begin
            int  lim;
            int  nx;
            bit  stp;
            lim = int'(limit);
            m_wrp[k] = 0;
            if (clr) begin
               m_cnt[k] = 0; m_pre[k] = 0; m_dn[k] = 0; m_ph[k] = 0;
            end else if (load) begin
               m_cnt[k] = int'(load_val); m_pre[k] = 0; m_dn[k] = 0;
               if (mode == 2) m_ph[k] = 1;
            end else begin
               stp = inc && (m_pre[k] == PR[k] - 1);
               if (inc) m_pre[k] = stp ? 0 : m_pre[k] + 1;
               if (stp) begin
                  nx = dir ? (m_cnt[k] + 1) % MOD : (m_cnt[k] + MOD - 1) % MOD;
                  if (mode == 1) begin
                     if (dir && m_cnt[k] > lim) m_cnt[k] = lim;
                     else if (!term_of(m_cnt[k])) m_cnt[k] = nx;
                  end else if (mode == 2) begin
                     if (m_ph[k] == 1) begin
                        if (term_of(m_cnt[k]) || term_of(nx)) begin
                           if (!term_of(m_cnt[k])) m_cnt[k] = nx;
                           m_wrp[k] = 1; m_dn[k] = 1; m_ph[k] = 2;
                        end else begin
                           m_cnt[k] = nx;
                        end
                     end
                  end else begin
                     if (term_of(m_cnt[k])) begin
                        m_cnt[k] = dir ? 0 : lim;
                        m_wrp[k] = 1;
                     end else begin
                        m_cnt[k] = nx;
                     end
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("A.cnt",     int'(a_cnt),  m_cnt[0]);
         chk("A.at_term", int'(a_at),   term_of(m_cnt[0]));
         chk("A.wrap",    int'(a_wrap), m_wrp[0]);
         chk("A.done",    int'(a_done), m_dn[0]);
         chk("B.cnt",     int'(b_cnt),  m_cnt[1]);
         chk("B.at_term", int'(b_at),   term_of(m_cnt[1]));
         chk("B.wrap",    int'(b_wrap), m_wrp[1]);
         chk("B.done",    int'(b_done), m_dn[1]);
      end
   end

   initial begin
      reset = 0; clr = 0; load = 0; load_val = 0; inc = 0;
      dir = 1; mode = 0; limit = 0;
      #1 reset = 1;
      tick();
      chk_en = 1;
      tick();
      chk("rst.cnt", int'(a_cnt), 0);
      chk("rst.at_term", int'(a_at), 1);
      chk("rst.wrap", int'(a_wrap), 0);
      chk("rst.done", int'(b_done), 0);
      reset = 0;

      // up wrap 0..9,0
      limit = 9; inc = 1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("up.cnt", int'(a_cnt), k % 10);
         chk("up.wrap", int'(a_wrap), int'(k == 10));
         if (k == 9) begin
            chk("up.term9", int'(a_at), 1);
            chk("presc.9inc", int'(b_cnt), 3);
         end
      end
      inc = 0; clr = 1; tick(); clr = 0;

      // gapped inc: prescaler holds across the gaps
      for (int k = 0; k < 5; k++) begin
         inc = (k % 2 == 0);
         tick();
      end
      inc = 0;
      chk("gap.B", int'(b_cnt), 1);
      chk("gap.A", int'(a_cnt), 3);

      // down wrap from 0 with limit 5
      clr = 1; tick(); clr = 0;
      dir = 0; limit = 5; inc = 1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("dn.cnt", int'(a_cnt), (k == 7) ? 5 : (6 - k) % 6);
         chk("dn.wrap", int'(a_wrap), int'(k == 1 || k == 7));
      end
      inc = 0;

      // saturate
      clr = 1; tick(); clr = 0;
      mode = 1; dir = 1; inc = 1;
      repeat (7) tick();
      chk("sat.cnt", int'(a_cnt), 5);
      chk("sat.wrap", int'(a_wrap), 0);
      inc = 0; clr = 1; tick(); clr = 0;
      inc = 1; repeat (4) tick(); inc = 0;
      chk("sat.at4", int'(a_cnt), 4);
      limit = 2; tick();
      inc = 1; tick(); inc = 0;
      chk("sat.lower", int'(a_cnt), 2);

      // one-shot
      clr = 1; tick(); clr = 0;
      mode = 2; limit = 4; inc = 1;
      repeat (2) tick();
      chk("os.idle", int'(a_cnt), 0);
      load = 1; load_val = 1; tick(); load = 0;
      chk("os.load", int'(a_cnt), 1);
      chk("os.load.done", int'(a_done), 0);
      repeat (3) tick();
      chk("os.cnt4", int'(a_cnt), 4);
      chk("os.done", int'(a_done), 1);
      chk("os.wrap", int'(a_wrap), 1);
      tick();
      chk("os.hold", int'(a_cnt), 4);
      chk("os.wrap1", int'(a_wrap), 0);
      chk("os.done.hold", int'(a_done), 1);
      load_val = 0; load = 1; tick(); load = 0;
      chk("os.reload", int'(a_cnt), 0);
      chk("os.reload.done", int'(a_done), 0);
      inc = 0;

      // priority corners
      mode = 0; load_val = 7; clr = 1; load = 1; inc = 1;
      tick();
      chk("prio.clr", int'(a_cnt), 0);
      clr = 0; tick();
      chk("prio.loadA", int'(a_cnt), 7);
      chk("prio.loadB", int'(b_cnt), 7);
      load = 0; inc = 0;

      // limit 0 up wrap pulses every step
      limit = 0; dir = 1; clr = 1; tick(); clr = 0;
      inc = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("lim0.wrap", int'(a_wrap), 1);
         chk("lim0.cnt", int'(a_cnt), 0);
      end
      inc = 0;

      // async reset mid-count
      clr = 1; tick(); clr = 0;
      limit = 9; inc = 1;
      repeat (3) tick();
      inc = 0;
      chk("ar.pre", int'(a_cnt), 3);
      #1 reset = 1;
      #1;
      chk("ar.A", int'(a_cnt), 0);
      chk("ar.B", int'(b_cnt), 0);
      tick();
      reset = 0; inc = 1;
      repeat (2) tick();
      chk("ar.B2", int'(b_cnt), 0);
      tick();
      chk("ar.B3", int'(b_cnt), 1);
      inc = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
